// File: rtl/divider_rs_scheduler.sv
// Two-requester round-robin front end for a repetitive-subtraction divider.
// Each CALC clock performs one compare/subtract step on a single shared datapath.
module divider_rs_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quot;
    logic             r_id;
    logic             r_dbz;
    logic             r_resp_valid;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_sel_id;
    logic [WIDTH-1:0] w_sel_dividend;
    logic [WIDTH-1:0] w_sel_divisor;

    // Round-robin grant; on a tie the requester not granted last wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst && (r_state == S_IDLE)) begin
            w_grant0 = req0_valid && (!req1_valid || r_last_grant);
            w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        w_accept       = w_grant0 || w_grant1;
        w_sel_id       = 1'b0;
        w_sel_dividend = {WIDTH{1'b0}};
        w_sel_divisor  = {WIDTH{1'b0}};
        if (w_grant1) begin
            w_sel_id       = 1'b1;
            w_sel_dividend = req1_dividend;
            w_sel_divisor  = req1_divisor;
        end else begin
            w_sel_id       = 1'b0;
            w_sel_dividend = req0_dividend;
            w_sel_divisor  = req0_divisor;
        end
    end

    // Scheduler FSM and divider datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_rem        <= {WIDTH{1'b0}};
            r_div        <= {WIDTH{1'b0}};
            r_quot       <= {WIDTH{1'b0}};
            r_id         <= 1'b0;
            r_dbz        <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem        <= w_sel_dividend;
                        r_div        <= w_sel_divisor;
                        r_id         <= w_sel_id;
                        r_last_grant <= w_sel_id;
                        if (w_sel_divisor == {WIDTH{1'b0}}) begin
                            r_quot       <= {WIDTH{1'b1}};
                            r_dbz        <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_quot  <= {WIDTH{1'b0}};
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // Quotient cannot overflow: at most 2^WIDTH-1 subtractions.
                    if (r_rem >= r_div) begin
                        r_rem  <= r_rem - r_div;
                        r_quot <= r_quot + {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_dbz        <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_id;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/divider_rs_scheduler.md
# divider_rs_scheduler

Sequential, two-requester front end for the team's repetitive-subtraction divider. It arbitrates round-robin between two requesters and accepts one operand pair at a time. It then performs one compare/subtract step per clock, so area stays at one subtractor and one comparator, and returns quotient, remainder and a divide-by-zero flag over a valid/ready response channel. It sits between shared arithmetic clients and replaces the unbounded combinational loop wherever the divider is time-shared.

## Interface
- WIDTH, 8, operand/result width in bits (unsigned)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 accepted on this edge when valid&ready
- req0_dividend / req0_divisor  in  WIDTH each  requester 0 operands
- req1_valid, req1_ready, req1_dividend, req1_divisor  same as requester 0
- resp_valid  out  1  result available, held until taken
- resp_ready  in  1  consumer takes result when valid&ready
- resp_id  out  1  index of requester that issued the result
- quotient  out  WIDTH  floor(dividend/divisor)
- remainder  out  WIDTH  dividend mod divisor
- div_by_zero  out  1  divisor was 0
- busy  out  1  high in CALC or DONE

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: reqN_ready is combinational.
  - Grant the single valid requester; if both are valid, grant the one not granted last.
  - last_grant resets to 1, so req0 wins the first tie.
  - Only the granted requester sees ready=1. Both readies are 0 while rst=1 and outside IDLE.
- Accept edge (valid&ready): latch dividend→rem, divisor→div, id→resp_id, quotient←0, and update last_grant.
  - divisor≠0: go to CALC.
  - divisor=0: go to DONE with quotient=all-ones, remainder=dividend, div_by_zero=1. No iterations run.
- CALC: each edge, if rem ≥ div then rem←rem−div and quotient←quotient+1; otherwise go to DONE.
  - Unsigned WIDTH-bit arithmetic throughout; quotient never wraps because q ≤ 2^WIDTH−1.
- DONE: resp_valid=1. quotient, remainder, resp_id and div_by_zero are held stable until the edge where resp_valid&resp_ready, then go to IDLE.
  - div_by_zero clears on that edge.
  - Results hold their values in IDLE until the next accept.
- Requesters hold valid and operands until accepted; operands are sampled only on the accept edge.
- Reset in any state: the in-flight operation is abandoned with no response, and all state returns to reset values on that edge.

## Timing
- Reset values: resp_valid=0, quotient=0, remainder=0, resp_id=0, div_by_zero=0, busy=0, req0_ready=req1_ready=0 while rst=1, last_grant=1.
- Accept at edge E0, quotient q:
  - divisor≠0: resp_valid rises at edge E0+q+1 (q subtracting edges plus one failing compare).
  - divisor=0: resp_valid rises at E0.
- Worst case: dividend=2^WIDTH−1, divisor=1, giving resp_valid at E0+2^WIDTH (256 for WIDTH=8).
- Response taken at edge Ed; next accept is possible at Ed+1 at the earliest. Throughput is one operation per q+3 cycles.
- resp_ready held high in DONE: response completes on the first DONE edge.
- Requests arriving in CALC/DONE wait; they are not dropped and no priority is lost.

## Test plan
- Reset: assert rst for 2 cycles, including mid-CALC (100/3 on req0, rst 10 cycles after accept) → all outputs at reset values, no resp_valid, then IDLE.
- Single op: req0 100/7, resp_ready=1 → resp_valid at E0+15, quotient=14, remainder=2, resp_id=0, div_by_zero=0. Also 5/9 → E0+1, q=0, r=5.
- Divide-by-zero: req1 42/0 → resp_valid at E0, quotient=255, remainder=42, div_by_zero=1, resp_id=1.
- Arbitration: both valid continuously, req0 6/2 and req1 9/3 → grants alternate 0,1,0,1. The loser's ready stays 0 and its operands are untouched.
- Back-pressure: 255/1 with resp_ready low for 20 cycles after resp_valid → quotient=255, remainder=0 held stable, no new accept; accept resumes at the cycle after the take.
- Randomized: 1000 random WIDTH=8 pairs, including 0 dividends and equal operands → results match the integer reference, and the latency equals q+1.
